// File: rtl/serial_crc_checker.sv
// Serial CRC checker: runs the Galois LFSR for G(y)=1+y+y7+y9 over data+check bits (MSB first)
// and recovers the data word. Define CRC_ERRCNT_EN to add the saturating err_cnt output.
module serial_crc_checker #(
  parameter int unsigned      DATA_W = 10,
  parameter int unsigned      CRC_W  = 9,
  parameter logic [CRC_W-1:0] POLY   = 9'h083
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              crc_ok
`ifdef CRC_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned TOT_W = DATA_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(TOT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CRC_W-1:0]    lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                crc_ok_q, crc_ok_d;
  logic                busy_q, done_q;

  logic [CRC_W-1:0]    lfsr_base, lfsr_step;
  logic [CNT_W-1:0]    cnt_base;
  logic                in_frame, in_data, fb;

`ifdef CRC_ERRCNT_EN
  logic [7:0]          err_q, err_d;
`endif

  // A start restarts the frame in the same cycle, so the accepted bit steps from a zero LFSR.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    data_out_d = data_out_q;
    crc_ok_d   = crc_ok_q;
`ifdef CRC_ERRCNT_EN
    err_d      = err_q;
`endif

    lfsr_base = start ? '0 : lfsr_q;
    cnt_base  = start ? '0 : cnt_q;
    in_frame  = start || (state_q == S_DATA) || (state_q == S_CHECK);
    in_data   = start || (state_q == S_DATA);
    fb        = lfsr_base[CRC_W-1] ^ bit_in;
    lfsr_step = {lfsr_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    if (state_q == S_DONE) state_d = S_IDLE;

    if (start) begin
      state_d = S_DATA;
      lfsr_d  = '0;
      cnt_d   = '0;
    end

    if (in_frame && bit_valid) begin
      lfsr_d = lfsr_step;
      cnt_d  = cnt_base + CNT_W'(1);
      if (in_data) begin
        sr_d = {sr_q[DATA_W-2:0], bit_in};
        if (cnt_d == CNT_W'(DATA_W)) state_d = S_CHECK;
      end else if (cnt_d == CNT_W'(TOT_W)) begin
        state_d    = S_DONE;
        data_out_d = sr_q;
        crc_ok_d   = (lfsr_step == '0);
`ifdef CRC_ERRCNT_EN
        if ((lfsr_step != '0) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      data_out_q <= '0;
      crc_ok_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CRC_ERRCNT_EN
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
      crc_ok_q   <= crc_ok_d;
      busy_q     <= (state_d == S_DATA) || (state_d == S_CHECK);
      done_q     <= (state_d == S_DONE);
`ifdef CRC_ERRCNT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign crc_ok   = crc_ok_q;
`ifdef CRC_ERRCNT_EN
  assign err_cnt  = err_q;
`endif

endmodule
